// File: rtl/seg7_pkg.sv
// Shared types and hex-to-segment lookup for the 7-segment scanner.
// Segment order is g..a, active-low.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h7F;

  localparam seg7_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg7_t hex2seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble/blank/dp to active-low segment and dp drive.
import seg7_pkg::*;

module seg7_decode (
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp_req,
  output seg7_t      seg,
  output logic       dp_n
);

  always_comb begin
    seg  = blank ? SEG7_BLANK : hex2seg(nibble);
    dp_n = ~dp_req;
  end

endmodule

// File: rtl/seg7_scanner.sv
// N-digit common-anode 7-segment scanner with frame shadow and blanking.
// Optional PWM dimming enabled by defining SEG7_DIM_EN.
import seg7_pkg::*;

module seg7_scanner #(
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4*NDIGITS-1:0] digits,
  input  logic [NDIGITS-1:0]   dps,
  input  logic                 lz_blank,
  input  logic [3:0]           brightness,
  output logic [NDIGITS-1:0]   an,
  output seg7_t                seg,
  output logic                 dp,
  output logic                 frame
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*NDIGITS-1:0] shd_dig_q, shd_dig_d;
  logic [NDIGITS-1:0]   shd_dps_q, shd_dps_d;
  logic [NDIGITS-1:0]   an_q, an_d;
  seg7_t                seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 frame_q, frame_d;

  logic                 tick;
  logic                 first;
  logic [4*NDIGITS-1:0] src_dig;
  logic [NDIGITS-1:0]   src_dps;
  logic [4*NDIGITS-1:0] hi_dig;
  logic [3:0]           cur_nib;
  logic                 cur_blank;
  logic                 cur_dp;
  logic [NDIGITS-1:0]   anode;
  seg7_t                dec_seg;
  logic                 dec_dp;

  assign tick  = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign first = (idx_q == '0);
  assign anode = ~(NDIGITS'(1) << idx_q);

  // Digit-0 slot reads the live inputs it is capturing this tick.
  always_comb begin
    src_dig   = first ? digits : shd_dig_q;
    src_dps   = first ? dps : shd_dps_q;
    hi_dig    = shd_dig_q >> {idx_q, 2'b00};
    cur_nib   = src_dig[{idx_q, 2'b00} +: 4];
    cur_dp    = src_dps[idx_q];
    cur_blank = lz_blank && !first && (hi_dig == '0);
  end

  seg7_decode u_dec (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .dp_req (cur_dp),
    .seg    (dec_seg),
    .dp_n   (dec_dp)
  );

`ifdef SEG7_DIM_EN
  localparam int PH = SCAN_DIV / 16;

  logic [CNT_W-1:0]   sub_q, sub_d;
  logic [3:0]         ph_q, ph_d;
  logic [3:0]         brt_q, brt_d;
  logic [NDIGITS-1:0] slot_an_q, slot_an_d;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    shd_dig_d = shd_dig_q;
    shd_dps_d = shd_dps_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    frame_d   = tick && first;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
      seg_d = dec_seg;
      dp_d  = dec_dp;
      if (first) begin
        shd_dig_d = digits;
        shd_dps_d = dps;
      end
    end
`ifdef SEG7_DIM_EN
    sub_d     = sub_q + 1'b1;
    ph_d      = ph_q;
    brt_d     = tick ? brightness : brt_q;
    slot_an_d = tick ? anode : slot_an_q;
    if (tick) begin
      sub_d = '0;
      ph_d  = '0;
    end else if (sub_q == CNT_W'(PH - 1)) begin
      sub_d = '0;
      ph_d  = ph_q + 1'b1;
    end
    an_d = (ph_d <= brt_d) ? slot_an_d : '1;
`else
    an_d = tick ? anode : an_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shd_dig_q <= '0;
      shd_dps_q <= '0;
      an_q      <= '1;
      seg_q     <= SEG7_BLANK;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
`ifdef SEG7_DIM_EN
      sub_q     <= '0;
      ph_q      <= '0;
      brt_q     <= '0;
      slot_an_q <= '1;
`endif
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shd_dig_q <= shd_dig_d;
      shd_dps_q <= shd_dps_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
`ifdef SEG7_DIM_EN
      sub_q     <= sub_d;
      ph_q      <= ph_d;
      brt_q     <= brt_d;
      slot_an_q <= slot_an_d;
`endif
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Bench for seg7_scanner (NDIGITS=4, SCAN_DIV=16): edge-count reference
// model checks an/seg/dp/frame every cycle under directed and random inputs.
module tb_seg7_scanner;

  localparam int ND  = 4;
  localparam int DIV = 16;

  localparam logic [6:0] TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dps;
  logic        lz_blank;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  seg7_scanner #(
    .NDIGITS  (ND),
    .SCAN_DIV (DIV),
    .CNT_W    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .dps        (dps),
    .lz_blank   (lz_blank),
    .brightness (brightness),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame      (frame)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  int          n      = 0;
  int          idx_m  = 0;
  int          slot_k = 0;
  int          brt_m  = 0;
  logic [15:0] snap   = '0;
  logic [3:0]  snapd  = '0;
  logic [3:0]  slot_an = 4'hF;
  logic [3:0]  e_an   = 4'hF;
  logic [6:0]  e_seg  = 7'h7F;
  logic        e_dp   = 1'b1;
  logic        e_fr   = 1'b0;

  // One clock edge of the reference model, then check all outputs.
  task automatic step();
    int nib;
    bit blank;
    @(posedge clk);
    if (reset) begin
      n = 0; slot_k = 0; slot_an = 4'hF;
      e_seg = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
    end else begin
      n++;
      slot_k++;
      e_fr = 1'b0;
      if (n % DIV == 0) begin
        idx_m = (n / DIV - 1) % ND;
        if (idx_m == 0) begin
          snap = digits;
          snapd = dps;
          e_fr = 1'b1;
        end
        nib = (snap >> (4 * idx_m)) & 15;
        blank = lz_blank && idx_m != 0 && (snap >> (4 * idx_m)) == 0;
        e_seg = blank ? 7'h7F : TAB[nib];
        e_dp = ~snapd[idx_m];
        slot_an = ~(4'b0001 << idx_m);
        slot_k = 0;
        brt_m = brightness;
      end
    end
`ifdef SEG7_DIM_EN
    e_an = (slot_k <= brt_m) ? slot_an : 4'hF;
`else
    e_an = slot_an;
`endif
    #1;
    checks++;
    assert (an === e_an) else begin
      fails++;
      $error("FAIL an n=%0d: observed %b expected %b", n, an, e_an);
    end
    checks++;
    assert (seg === e_seg) else begin
      fails++;
      $error("FAIL seg n=%0d: observed %h expected %h", n, seg, e_seg);
    end
    checks++;
    assert (dp === e_dp) else begin
      fails++;
      $error("FAIL dp n=%0d: observed %b expected %b", n, dp, e_dp);
    end
    checks++;
    assert (frame === e_fr) else begin
      fails++;
      $error("FAIL frame n=%0d: observed %b expected %b", n, frame, e_fr);
    end
  endtask

  task automatic run(input int cyc);
    for (int i = 0; i < cyc; i++) step();
  endtask

  // Advance until the model is a few cycles into the digit-2 slot.
  task automatic to_digit2();
    int guard = 0;
    while (!(n >= DIV && idx_m == 2 && slot_k == 3) && guard < 200) begin
      step();
      guard++;
    end
    checks++;
    assert (guard < 200) else begin
      fails++;
      $error("FAIL wait_digit2: observed %0d cycles expected <200", guard);
    end
  endtask

  initial begin
    reset = 1'b1;
    digits = 16'h1234;
    dps = 4'b0000;
    lz_blank = 1'b0;
    brightness = 4'd3;
    step();
    step();
    reset = 1'b0;
    run(8 * DIV + 2);

    digits = 16'h0050;
    lz_blank = 1'b1;
    run(8 * DIV);

    digits = 16'h0000;
    dps = 4'b0100;
    run(8 * DIV);

    brightness = 4'd15;
    dps = 4'b0000;
    lz_blank = 1'b0;
    digits = 16'hAAAA;
    run(4 * DIV);
    to_digit2();
    digits = 16'h5555;
    run(8 * DIV);

    to_digit2();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(5 * DIV);

    for (int r = 0; r < 24; r++) begin
      digits = 16'($urandom);
      dps = 4'($urandom);
      lz_blank = 1'($urandom);
      brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        digits = digits & 16'h00FF;
        lz_blank = 1'b1;
      end
      run($urandom_range(1, 90));
      if ($urandom_range(0, 11) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
    end
    run(4 * DIV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
